// File: rtl/dma_channel_pkg.sv
// Shared constants, FSM encoding and address helpers for the single-channel DMA initiator.
package dma_channel_pkg;

   localparam logic [15:0] RAM_LO      = 16'h1C00;
   localparam logic [15:0] FRAM_HI     = 16'hFFFF;
   localparam logic [15:0] DMA_ADDR_LO = RAM_LO;
   localparam logic [15:0] DMA_ADDR_HI = FRAM_HI;

   typedef enum logic [2:0] {
      DMA_IDLE = 3'd0,
      DMA_REQ  = 3'd1,
      DMA_RD   = 3'd2,
      DMA_WR   = 3'd3,
      DMA_DONE = 3'd4
   } dma_state_e;

   function automatic logic [15:0] dma_align(input logic [15:0] addr, input logic byte_mode);
      logic [15:0] a;
      if (byte_mode) begin
         a = addr;
      end else begin
         a = {addr[15:1], 1'b0};
      end
      return a;
   endfunction

   function automatic logic dma_in_range(input logic [15:0] addr, input logic [15:0] lo,
                                         input logic [15:0] hi);
      return (addr >= lo) && (addr <= hi);
   endfunction

endpackage

// File: rtl/dma_channel_if.sv
// Memory-bus signals shared between a bus initiator (master) and the memory side (slave).
interface dma_channel_if;
   logic        REQ;
   logic        GNT;
   logic [15:0] MAB;
   logic [15:0] MDBwrite;
   logic [15:0] MDBread;
   logic        MW;
   logic        BW;

   modport master (output REQ, MAB, MDBwrite, MW, BW, input GNT, MDBread);
   modport slave  (input REQ, MAB, MDBwrite, MW, BW, output GNT, MDBread);
endinterface

// File: rtl/dma_addr_step.sv
// Per-pointer address helper: bus-aligned address, stepped address and range flags for both.
module dma_addr_step
   import dma_channel_pkg::*;
#(
   parameter logic [15:0] ADDR_LO = DMA_ADDR_LO,
   parameter logic [15:0] ADDR_HI = DMA_ADDR_HI
) (
   input  logic [15:0] addr_i,
   input  logic        byte_i,
   input  logic        inc_i,
   output logic [15:0] bus_addr_o,
   output logic [15:0] next_addr_o,
   output logic        in_range_o,
   output logic        next_in_range_o
);
   logic [15:0] step_s;

   // Stepping wraps modulo 2^16; the range check always looks at the aligned address
   always_comb begin
      step_s          = byte_i ? 16'd1 : 16'd2;
      bus_addr_o      = dma_align(addr_i, byte_i);
      next_addr_o     = inc_i ? (addr_i + step_s) : addr_i;
      in_range_o      = dma_in_range(bus_addr_o, ADDR_LO, ADDR_HI);
      next_in_range_o = dma_in_range(dma_align(next_addr_o, byte_i), ADDR_LO, ADDR_HI);
   end
endmodule

// File: rtl/dma_channel.sv
// Single-channel block-copy bus initiator; bus outputs are zero outside RD/WR so they can be ORed with the CPU's.
module dma_channel
   import dma_channel_pkg::*;
#(
   parameter logic [15:0] ADDR_LO = DMA_ADDR_LO,
   parameter logic [15:0] ADDR_HI = DMA_ADDR_HI
) (
   input  logic                MCLK,
   input  logic                reset,
   input  logic                start,
   input  logic [15:0]         SRC,
   input  logic [15:0]         DST,
   input  logic [15:0]         SZ,
   input  logic                BYTE,
   input  logic                SRCINC,
   input  logic                DSTINC,
   output logic                BUSY,
   output logic                DONE,
   output logic                ERR,
   dma_channel_if.master       bus
);
   dma_state_e  state_q, state_d;
   logic [15:0] src_q, src_d, dst_q, dst_d, rem_q, rem_d, hold_q, hold_d;
   logic        byte_q, byte_d, srcinc_q, srcinc_d, dstinc_q, dstinc_d, err_q, err_d;

   logic [15:0] src_bus_s, src_next_s, dst_bus_s, dst_next_s;
   logic        src_ok_s, src_next_ok_s, dst_ok_s, dst_next_ok_s;

   dma_addr_step #(.ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI)) u_src_step (
      .addr_i(src_q), .byte_i(byte_q), .inc_i(srcinc_q),
      .bus_addr_o(src_bus_s), .next_addr_o(src_next_s),
      .in_range_o(src_ok_s), .next_in_range_o(src_next_ok_s)
   );

   dma_addr_step #(.ADDR_LO(ADDR_LO), .ADDR_HI(ADDR_HI)) u_dst_step (
      .addr_i(dst_q), .byte_i(byte_q), .inc_i(dstinc_q),
      .bus_addr_o(dst_bus_s), .next_addr_o(dst_next_s),
      .in_range_o(dst_ok_s), .next_in_range_o(dst_next_ok_s)
   );

   // State and datapath registers
   always_ff @(posedge MCLK or negedge reset) begin
      if (!reset) begin
         state_q  <= DMA_IDLE;
         src_q    <= 16'h0000;
         dst_q    <= 16'h0000;
         rem_q    <= 16'h0000;
         hold_q   <= 16'h0000;
         byte_q   <= 1'b0;
         srcinc_q <= 1'b0;
         dstinc_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         src_q    <= src_d;
         dst_q    <= dst_d;
         rem_q    <= rem_d;
         hold_q   <= hold_d;
         byte_q   <= byte_d;
         srcinc_q <= srcinc_d;
         dstinc_q <= dstinc_d;
         err_q    <= err_d;
      end
   end

   // Next-state logic; the range check for a unit is made just before its RD is entered
   always_comb begin
      state_d  = state_q;
      src_d    = src_q;
      dst_d    = dst_q;
      rem_d    = rem_q;
      hold_d   = hold_q;
      byte_d   = byte_q;
      srcinc_d = srcinc_q;
      dstinc_d = dstinc_q;
      err_d    = err_q;
      case (state_q)
         DMA_IDLE: begin
            if (start) begin
               src_d    = SRC;
               dst_d    = DST;
               rem_d    = SZ;
               byte_d   = BYTE;
               srcinc_d = SRCINC;
               dstinc_d = DSTINC;
               err_d    = 1'b0;
               state_d  = (SZ == 16'd0) ? DMA_DONE : DMA_REQ;
            end else begin
               state_d = DMA_IDLE;
            end
         end
         DMA_REQ: begin
            if (!(src_ok_s && dst_ok_s)) begin
               err_d   = 1'b1;
               state_d = DMA_DONE;
            end else if (bus.GNT) begin
               state_d = DMA_RD;
            end else begin
               state_d = DMA_REQ;
            end
         end
         DMA_RD: begin
            hold_d  = bus.MDBread;
            state_d = DMA_WR;
         end
         DMA_WR: begin
            rem_d = (rem_q != 16'd0) ? (rem_q - 16'd1) : 16'd0;
            src_d = src_next_s;
            dst_d = dst_next_s;
            if (rem_d == 16'd0) begin
               state_d = DMA_DONE;
            end else if (!(src_next_ok_s && dst_next_ok_s)) begin
               err_d   = 1'b1;
               state_d = DMA_DONE;
            end else if (bus.GNT) begin
               state_d = DMA_RD;
            end else begin
               state_d = DMA_REQ;
            end
         end
         DMA_DONE: state_d = DMA_IDLE;
         default:  state_d = DMA_IDLE;
      endcase
   end

   // Bus and status outputs decoded from the registered state only
   always_comb begin
      bus.REQ      = 1'b0;
      bus.MAB      = 16'h0000;
      bus.MDBwrite = 16'h0000;
      bus.MW       = 1'b0;
      bus.BW       = 1'b0;
      BUSY         = 1'b0;
      DONE         = 1'b0;
      ERR          = err_q;
      case (state_q)
         DMA_REQ: begin
            bus.REQ = 1'b1;
            BUSY    = 1'b1;
         end
         DMA_RD: begin
            bus.REQ = 1'b1;
            bus.MAB = src_bus_s;
            bus.BW  = byte_q;
            BUSY    = 1'b1;
         end
         DMA_WR: begin
            bus.REQ      = 1'b1;
            bus.MAB      = dst_bus_s;
            bus.MDBwrite = byte_q ? {8'h00, hold_q[7:0]} : hold_q;
            bus.MW       = 1'b1;
            bus.BW       = byte_q;
            BUSY         = 1'b1;
         end
         DMA_DONE: DONE = 1'b1;
         default: begin
            DONE = 1'b0;
         end
      endcase
   end
endmodule

// File: tb/tb_dma_channel.sv
// Self-checking bench for dma_channel: byte-addressed memory model on the bus plus a unit-level copy reference.
module tb_dma_channel;
   localparam int LO = 'h1C00;
   localparam int HI = 'hFFFF;

   logic        MCLK = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [15:0] SRC = 16'h0, DST = 16'h0, SZ = 16'h0;
   logic        BYTE = 1'b0, SRCINC = 1'b0, DSTINC = 1'b0;
   logic        BUSY, DONE, ERR;

   dma_channel_if bus();

   dma_channel dut (
      .MCLK(MCLK), .reset(reset), .start(start), .SRC(SRC), .DST(DST), .SZ(SZ),
      .BYTE(BYTE), .SRCINC(SRCINC), .DSTINC(DSTINC), .BUSY(BUSY), .DONE(DONE),
      .ERR(ERR), .bus(bus)
   );

   always #5 MCLK = ~MCLK;

   logic [7:0]  mem     [0:65535];
   logic [7:0]  ref_mem [0:65535];
   logic [15:0] rd_got[$], wr_got[$], rd_exp[$], wr_exp[$];
   int          n_tests = 0, n_fail = 0, bus_viol = 0;
   logic        cur_byte = 1'b0;

   assign bus.MDBread = bus.BW ? {8'h00, mem[bus.MAB]}
                               : {mem[{bus.MAB[15:1], 1'b1}], mem[{bus.MAB[15:1], 1'b0}]};

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Bus monitor: performs memory writes and logs every bus cycle
   always @(negedge MCLK) begin
      if (reset && bus.MAB != 16'h0000) begin
         if (bus.MW) begin
            wr_got.push_back(bus.MAB);
            if (bus.BW) begin
               mem[bus.MAB] = bus.MDBwrite[7:0];
               if (bus.MDBwrite[15:8] != 8'h00) bus_viol++;
            end else begin
               mem[{bus.MAB[15:1], 1'b0}] = bus.MDBwrite[7:0];
               mem[{bus.MAB[15:1], 1'b1}] = bus.MDBwrite[15:8];
            end
         end else begin
            rd_got.push_back(bus.MAB);
         end
         if (bus.BW != cur_byte || !bus.REQ) bus_viol++;
      end
      if (!bus.REQ && (bus.MW || bus.BW || bus.MAB != 16'h0 || bus.MDBwrite != 16'h0)) bus_viol++;
   end

   task automatic init_mem();
      for (int i = 0; i < 65536; i++) begin
         mem[i]     = 8'($urandom);
         ref_mem[i] = mem[i];
      end
   endtask

   task automatic poke_word(input logic [15:0] a, input logic [15:0] v);
      mem[a] = v[7:0];         ref_mem[a] = v[7:0];
      mem[a | 16'd1] = v[15:8]; ref_mem[a | 16'd1] = v[15:8];
   endtask

   // Reference: copy unit by unit, stopping at the first unit whose aligned address is illegal
   task automatic model(input logic [15:0] s0, d0, n, input logic b, si, di,
                        output int moved, output logic err);
      logic [15:0] s, d, a, w, step;
      s = s0; d = d0; moved = 0; err = 1'b0;
      step = b ? 16'd1 : 16'd2;
      for (int u = 0; u < int'(n); u++) begin
         a = b ? s : (s & 16'hFFFE);
         w = b ? d : (d & 16'hFFFE);
         if (int'(a) < LO || int'(a) > HI || int'(w) < LO || int'(w) > HI) begin
            err = 1'b1;
            break;
         end
         rd_exp.push_back(a);
         wr_exp.push_back(w);
         ref_mem[w] = ref_mem[a];
         if (!b) ref_mem[w | 16'd1] = ref_mem[a | 16'd1];
         moved++;
         if (si) s = s + step;
         if (di) d = d + step;
      end
   endtask

   // gmode: 0 GNT held, 1 random GNT, 2 GNT low for 5 cycles, 3 GNT dropped at first RD
   task automatic run_xfer(input logic [15:0] s, d, n, input logic b, si, di,
                           input int gmode, input logic poke, input string tag);
      int   moved, exp_cyc, cyc, hold_off, req_idle, early_bad, mism, diff;
      logic exp_err, seen_rd;
      rd_exp.delete(); wr_exp.delete(); rd_got.delete(); wr_got.delete();
      model(s, d, n, b, si, di, moved, exp_err);
      exp_cyc = (n == 16'd0) ? 1 : ((moved == 0) ? 2 : 2 + 2 * moved);
      @(negedge MCLK);
      bus_viol = 0;
      SRC = s; DST = d; SZ = n; BYTE = b; SRCINC = si; DSTINC = di; start = 1'b1; cur_byte = b;
      bus.GNT = (gmode == 2) ? 1'b0 : ((gmode == 1) ? 1'($urandom_range(0, 1)) : 1'b1);
      @(negedge MCLK);
      start = 1'b0;
      cyc = 1; seen_rd = 1'b0; hold_off = 0; req_idle = 0; early_bad = 0;
      check({tag, "_busy1"}, 32'(BUSY), 32'(n != 16'd0));
      check({tag, "_req1"}, 32'(bus.REQ), 32'(n != 16'd0));
      while (!DONE && cyc < 400) begin
         if (seen_rd && bus.REQ && bus.MAB == 16'h0) req_idle++;
         if (gmode == 2 && cyc <= 5 && (bus.MW || !bus.REQ)) early_bad++;
         if (poke && cyc == 2) begin
            start = 1'b1; SRC = 16'($urandom); DST = 16'($urandom); SZ = 16'($urandom_range(1, 5));
            BYTE = ~b;
         end else begin
            start = 1'b0;
         end
         case (gmode)
            0: bus.GNT = 1'b1;
            1: bus.GNT = 1'($urandom_range(0, 1));
            2: bus.GNT = (cyc > 5);
            default: begin
               if (!seen_rd && bus.MAB != 16'h0 && !bus.MW) begin
                  seen_rd = 1'b1;
                  hold_off = 3;
               end
               if (hold_off > 0) begin
                  bus.GNT = 1'b0;
                  hold_off--;
               end else begin
                  bus.GNT = 1'b1;
               end
            end
         endcase
         @(negedge MCLK);
         cyc++;
      end
      start = 1'b0;
      check({tag, "_done_seen"}, 32'(DONE), 32'd1);
      if (gmode == 0) check({tag, "_done_cyc"}, 32'(cyc), 32'(exp_cyc));
      if (gmode == 2) check({tag, "_gnt_wait"}, 32'(early_bad), 32'd0);
      if (gmode == 3) check({tag, "_rereq"}, 32'(req_idle > 0), 32'(moved >= 2));
      check({tag, "_err"}, 32'(ERR), 32'(exp_err));
      check({tag, "_busy_done"}, 32'(BUSY), 32'd0);
      if (poke) begin
         start = 1'b1; SZ = 16'd3;
      end
      @(negedge MCLK);
      start = 1'b0;
      check({tag, "_done_pulse"}, 32'(DONE), 32'd0);
      check({tag, "_idle_busy"}, 32'(BUSY), 32'd0);
      check({tag, "_idle_req"}, 32'(bus.REQ), 32'd0);
      check({tag, "_rd_cnt"}, 32'(rd_got.size()), 32'(rd_exp.size()));
      check({tag, "_wr_cnt"}, 32'(wr_got.size()), 32'(wr_exp.size()));
      mism = 0;
      for (int i = 0; i < rd_got.size() && i < rd_exp.size(); i++) if (rd_got[i] != rd_exp[i]) mism++;
      for (int i = 0; i < wr_got.size() && i < wr_exp.size(); i++) if (wr_got[i] != wr_exp[i]) mism++;
      check({tag, "_addr_seq"}, 32'(mism), 32'd0);
      check({tag, "_bus_rules"}, 32'(bus_viol), 32'd0);
      diff = 0;
      for (int i = 0; i < 65536; i++) if (mem[i] !== ref_mem[i]) diff++;
      check({tag, "_mem"}, 32'(diff), 32'd0);
   endtask

   initial begin
      logic [7:0] keep22, keep25;
      int          k;
      bus.GNT = 1'b0;
      init_mem();
      repeat (3) @(negedge MCLK);
      check("rst_ctl", {26'd0, bus.REQ, bus.MW, bus.BW, BUSY, DONE, ERR}, 32'd0);
      check("rst_mab", 32'(bus.MAB), 32'd0);
      check("rst_mdbw", 32'(bus.MDBwrite), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge MCLK);
      check("idle_after_rst", {29'd0, bus.REQ, BUSY, DONE}, 32'd0);

      poke_word(16'h4400, 16'h1234); poke_word(16'h4402, 16'h5678); poke_word(16'h4404, 16'h9ABC);
      run_xfer(16'h4400, 16'h4420, 16'd3, 1'b0, 1'b1, 1'b1, 0, 1'b0, "t1");
      check("t1_w0", {16'd0, mem[16'h4421], mem[16'h4420]}, 32'h1234);
      check("t1_w1", {16'd0, mem[16'h4423], mem[16'h4422]}, 32'h5678);
      check("t1_w2", {16'd0, mem[16'h4425], mem[16'h4424]}, 32'h9ABC);

      mem[16'h4401] = 8'hAB; ref_mem[16'h4401] = 8'hAB;
      mem[16'h4402] = 8'hCD; ref_mem[16'h4402] = 8'hCD;
      keep22 = mem[16'h4422]; keep25 = mem[16'h4425];
      run_xfer(16'h4401, 16'h4423, 16'd2, 1'b1, 1'b1, 1'b1, 0, 1'b0, "t2");
      check("t2_b23", 32'(mem[16'h4423]), 32'hAB);
      check("t2_b24", 32'(mem[16'h4424]), 32'hCD);
      check("t2_b22", 32'(mem[16'h4422]), 32'(keep22));
      check("t2_b25", 32'(mem[16'h4425]), 32'(keep25));

      poke_word(16'h4404, 16'h1111); poke_word(16'h4406, 16'h2222); poke_word(16'h4408, 16'h3333);
      run_xfer(16'h4405, 16'h4430, 16'd2, 1'b0, 1'b1, 1'b0, 0, 1'b0, "t3");
      check("t3_dst", {16'd0, mem[16'h4431], mem[16'h4430]}, 32'h2222);
      if (rd_got.size() >= 2) begin
         check("t3_rd0", 32'(rd_got[0]), 32'h4404);
         check("t3_rd1", 32'(rd_got[1]), 32'h4406);
      end

      run_xfer(16'h4440, 16'h4460, 16'd2, 1'b0, 1'b1, 1'b1, 2, 1'b0, "t4a");
      run_xfer(16'h4470, 16'h4490, 16'd3, 1'b0, 1'b1, 1'b1, 3, 1'b0, "t4b");

      run_xfer(16'h1BFE, 16'h4440, 16'd2, 1'b0, 1'b1, 1'b1, 0, 1'b0, "t5a");
      check("t5a_no_mw", 32'(wr_got.size()), 32'd0);
      run_xfer(16'hFFFE, 16'h4440, 16'd2, 1'b0, 1'b1, 1'b1, 0, 1'b0, "t5b");
      check("t5b_moved", 32'(wr_got.size()), 32'd1);
      @(negedge MCLK);
      check("t5_err_sticky", 32'(ERR), 32'd1);

      run_xfer(16'h4400, 16'h4500, 16'd0, 1'b0, 1'b1, 1'b1, 0, 1'b0, "t6_sz0");
      run_xfer(16'h4500, 16'h4510, 16'd3, 1'b0, 1'b1, 1'b1, 0, 1'b1, "t6_busy");

      // Reset asserted in the middle of a WR cycle
      @(negedge MCLK);
      SRC = 16'h4600; DST = 16'h4700; SZ = 16'd4; BYTE = 1'b0; SRCINC = 1'b1; DSTINC = 1'b1;
      cur_byte = 1'b0; bus.GNT = 1'b1; start = 1'b1;
      @(negedge MCLK);
      start = 1'b0;
      k = 0;
      while (!bus.MW && k < 50) begin
         @(negedge MCLK);
         k++;
      end
      check("t6_rst_saw_wr", 32'(bus.MW), 32'd1);
      #1 reset = 1'b0;
      #1;
      check("t6_rst_async", {26'd0, bus.REQ, bus.MW, bus.BW, BUSY, DONE, ERR}, 32'd0);
      check("t6_rst_bus", {bus.MAB, bus.MDBwrite}, 32'd0);
      @(negedge MCLK);
      reset = 1'b1;
      @(negedge MCLK);
      check("t6_rst_idle", {29'd0, bus.REQ, BUSY, DONE}, 32'd0);
      init_mem();

      for (int t = 0; t < 40; t++) begin
         logic [15:0] rs, rd;
         int          sel;
         sel = $urandom_range(0, 9);
         rs = (sel == 0) ? 16'(16'h1BF0 + $urandom_range(0, 31)) :
              (sel == 1) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'(16'h4400 + $urandom_range(0, 255));
         sel = $urandom_range(0, 9);
         rd = (sel == 0) ? 16'(16'h1BF0 + $urandom_range(0, 31)) :
              (sel == 1) ? 16'(16'hFFF0 + $urandom_range(0, 15)) : 16'(16'h4800 + $urandom_range(0, 255));
         run_xfer(rs, rd, 16'($urandom_range(0, 6)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, 1), ($urandom_range(0, 3) == 0), "rnd");
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
